// File: rtl/breath_pkg.sv
// Shared definitions for the LED breathing-envelope sequencer.
package breath_pkg;

    localparam int DUTY_W_DEFAULT = 8;
    localparam int TICK_W_DEFAULT = 24;
    localparam int HOLD_W_DEFAULT = 8;

    // Envelope phase; the numeric encoding is visible on the phase output.
    typedef enum logic [2:0] {
        PH_IDLE      = 3'd0,
        PH_RAMP_UP   = 3'd1,
        PH_HOLD_HIGH = 3'd2,
        PH_RAMP_DOWN = 3'd3,
        PH_HOLD_LOW  = 3'd4
    } phase_e;

endpackage

// File: rtl/step_timebase.sv
// Step timebase: divides the clock by the live step period and aligns each
// resulting step to the next PWM period start.
//
// Strobe semantics: pwm_sync is a one-cycle pulse from the PWM at counter wrap.
// step_strobe is high for exactly one cycle when a step is owed (pending, or
// the divider wraps this same cycle) and pwm_sync is high. Several divider
// wraps before a sync collapse into one owed step.
module step_timebase #(
    parameter int TICK_W = breath_pkg::TICK_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              pwm_sync,
    input  logic [TICK_W-1:0] step_period,
    output logic              step_strobe
);

    logic [TICK_W-1:0] tick_q, tick_d;
    logic              pending_q, pending_d;
    logic [TICK_W-1:0] last_tick;
    logic              wrap;

    // Divider wrap detection, owed-step bookkeeping and strobe generation.
    always_comb begin
        last_tick   = (step_period == '0) ? '0 : step_period - TICK_W'(1);
        // >= keeps the divider sane if the live period shrinks below tick.
        wrap        = run && (tick_q >= last_tick);
        step_strobe = run && pwm_sync && (pending_q || wrap);
        tick_d      = tick_q;
        pending_d   = pending_q;
        if (!run) begin
            tick_d    = '0;
            pending_d = 1'b0;
        end else begin
            tick_d = wrap ? '0 : tick_q + TICK_W'(1);
            if (step_strobe) begin
                pending_d = 1'b0;
            end else if (wrap) begin
                pending_d = 1'b1;
            end
        end
    end

    // Divider and pending-step registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            tick_q    <= tick_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/breath_sequencer.sv
// Breathing-envelope controller: produces the duty_cycle stream for the PWM
// as ramp up, hold high, ramp down, hold low, with steps aligned to PWM
// period starts. Limits and hold counts are captured at each breath start.
module breath_sequencer
    import breath_pkg::*;
#(
    parameter int DUTY_W = DUTY_W_DEFAULT,
    parameter int TICK_W = TICK_W_DEFAULT,
    parameter int HOLD_W = HOLD_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [TICK_W-1:0] step_period,
    input  logic [DUTY_W-1:0] duty_min,
    input  logic [DUTY_W-1:0] duty_max,
    input  logic [HOLD_W-1:0] hold_high_steps,
    input  logic [HOLD_W-1:0] hold_low_steps,
    input  logic              pwm_sync,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic [2:0]        phase,
    output logic              cycle_done
);

    phase_e            state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [DUTY_W-1:0] min_l_q, min_l_d, max_l_q, max_l_d;
    logic [HOLD_W-1:0] hh_l_q, hh_l_d, hl_l_q, hl_l_d;
    logic              cycle_done_q, cycle_done_d;
    logic              step;
    logic              latch_cfg;
    logic              end_breath;
    logic              hold_last;

    step_timebase #(.TICK_W(TICK_W)) u_timebase (
        .clk         (clk),
        .rst         (rst),
        .run         (enable && (state_q != PH_IDLE)),
        .pwm_sync    (pwm_sync),
        .step_period (step_period),
        .step_strobe (step)
    );

    // State register plus duty, hold counter and latched configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= PH_IDLE;
            duty_q       <= '0;
            hold_cnt_q   <= '0;
            min_l_q      <= '0;
            max_l_q      <= '0;
            hh_l_q       <= '0;
            hl_l_q       <= '0;
            cycle_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            duty_q       <= duty_d;
            hold_cnt_q   <= hold_cnt_d;
            min_l_q      <= min_l_d;
            max_l_q      <= max_l_d;
            hh_l_q       <= hh_l_d;
            hl_l_q       <= hl_l_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    // Next state: envelope walk on each step; a zero hold count skips the dwell.
    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        hold_cnt_d = hold_cnt_q;
        latch_cfg  = 1'b0;
        end_breath = 1'b0;
        hold_last  = (hold_cnt_q == '0) || (hold_cnt_q == HOLD_W'(1));
        if (!enable) begin
            state_d    = PH_IDLE;
            duty_d     = '0;
            hold_cnt_d = '0;
        end else begin
            case (state_q)
                PH_IDLE: begin
                    latch_cfg = 1'b1;
                    duty_d    = duty_min;
                    state_d   = PH_RAMP_UP;
                end
                PH_RAMP_UP: if (step) begin
                    // >= also covers max_l <= min_l: the ramp ends at once.
                    if (duty_q >= max_l_q) begin
                        state_d    = (hh_l_q == '0) ? PH_RAMP_DOWN : PH_HOLD_HIGH;
                        hold_cnt_d = hh_l_q;
                    end else begin
                        duty_d = duty_q + DUTY_W'(1);
                    end
                end
                PH_HOLD_HIGH: if (step) begin
                    if (hold_last) state_d = PH_RAMP_DOWN;
                    else           hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
                PH_RAMP_DOWN: if (step) begin
                    if (duty_q <= min_l_q) begin
                        if (hl_l_q == '0) begin
                            end_breath = 1'b1;
                        end else begin
                            state_d    = PH_HOLD_LOW;
                            hold_cnt_d = hl_l_q;
                        end
                    end else begin
                        duty_d = duty_q - DUTY_W'(1);
                    end
                end
                PH_HOLD_LOW: if (step) begin
                    if (hold_last) end_breath = 1'b1;
                    else           hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
                default: begin
                    state_d = PH_IDLE;
                    duty_d  = '0;
                end
            endcase
            if (end_breath) begin
                latch_cfg = 1'b1;
                duty_d    = duty_min;
                state_d   = PH_RAMP_UP;
            end
        end
        min_l_d = latch_cfg ? duty_min        : min_l_q;
        max_l_d = latch_cfg ? duty_max        : max_l_q;
        hh_l_d  = latch_cfg ? hold_high_steps : hh_l_q;
        hl_l_d  = latch_cfg ? hold_low_steps  : hl_l_q;
    end

    // Outputs: all registered; cycle_done pulses the cycle after a breath ends.
    always_comb begin
        cycle_done_d = end_breath;
        duty_cycle   = duty_q;
        phase        = state_q;
        cycle_done   = cycle_done_q;
    end

endmodule

// File: tb/tb_breath_sequencer.sv
// Bench for breath_sequencer: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a breath-list reference model.
module tb_breath_sequencer;

    localparam int DUTY_W = 8;
    localparam int TICK_W = 24;
    localparam int HOLD_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [TICK_W-1:0] step_period;
    logic [DUTY_W-1:0] duty_min;
    logic [DUTY_W-1:0] duty_max;
    logic [HOLD_W-1:0] hold_high_steps;
    logic [HOLD_W-1:0] hold_low_steps;
    logic              pwm_sync;
    logic [DUTY_W-1:0] duty_cycle;
    logic [2:0]        phase;
    logic              cycle_done;

    int total = 0;
    int bad   = 0;

    // Clock generation.
    always #5 clk = ~clk;

    breath_sequencer #(.DUTY_W(DUTY_W), .TICK_W(TICK_W), .HOLD_W(HOLD_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .step_period     (step_period),
        .duty_min        (duty_min),
        .duty_max        (duty_max),
        .hold_high_steps (hold_high_steps),
        .hold_low_steps  (hold_low_steps),
        .pwm_sync        (pwm_sync),
        .duty_cycle      (duty_cycle),
        .phase           (phase),
        .cycle_done      (cycle_done)
    );

    // Reference model: a breath is a list of (duty, phase) step intervals.
    int m_phase = 0;
    int m_duty  = 0;
    int m_tick  = 0;
    bit m_pend  = 0;
    bit m_done  = 0;
    bit m_step  = 0;
    int seq_d[$];
    int seq_p[$];
    int idx = 0;

    function automatic void build_breath(int mn, int mx, int hh, int hl);
        int top;
        seq_d.delete();
        seq_p.delete();
        top = (mx > mn) ? mx : mn;
        for (int d = mn; d <= top; d++) begin seq_d.push_back(d); seq_p.push_back(1); end
        for (int i = 0; i < hh; i++)    begin seq_d.push_back(top); seq_p.push_back(2); end
        for (int d = top; d >= mn; d--) begin seq_d.push_back(d); seq_p.push_back(3); end
        for (int i = 0; i < hl; i++)    begin seq_d.push_back(mn); seq_p.push_back(4); end
    endfunction

    function automatic void model_update();
        int eff;
        bit running;
        bit wrap;
        m_step = 0;
        m_done = 0;
        if (rst) begin
            m_phase = 0; m_duty = 0; m_tick = 0; m_pend = 0;
            return;
        end
        running = enable && (m_phase != 0);
        eff     = (step_period == 0) ? 1 : int'(step_period);
        wrap    = running && (m_tick >= eff - 1);
        m_step  = running && pwm_sync && (m_pend || wrap);
        if (!running) begin
            m_tick = 0;
            m_pend = 0;
        end else begin
            m_tick = wrap ? 0 : m_tick + 1;
            if (m_step) m_pend = 0;
            else if (wrap) m_pend = 1;
        end
        if (!enable) begin
            m_phase = 0;
            m_duty  = 0;
        end else if (m_phase == 0) begin
            build_breath(int'(duty_min), int'(duty_max), int'(hold_high_steps), int'(hold_low_steps));
            idx = 0;
            m_duty  = seq_d[0];
            m_phase = seq_p[0];
        end else if (m_step) begin
            idx++;
            if (idx >= seq_d.size()) begin
                m_done = 1;
                build_breath(int'(duty_min), int'(duty_max), int'(hold_high_steps), int'(hold_low_steps));
                idx = 0;
            end
            m_duty  = seq_d[idx];
            m_phase = seq_p[idx];
        end
    endfunction

    // One clock: advance the model with the inputs seen at the edge, then check.
    task automatic cyc();
        @(posedge clk);
        model_update();
        #1;
        total++;
        if (duty_cycle !== DUTY_W'(m_duty)) begin
            bad++;
            $display("FAIL model_duty t=%0t: got %0d want %0d", $time, duty_cycle, m_duty);
        end
        total++;
        if (phase !== 3'(m_phase)) begin
            bad++;
            $display("FAIL model_phase t=%0t: got %0d want %0d", $time, phase, m_phase);
        end
        total++;
        if (cycle_done !== m_done) begin
            bad++;
            $display("FAIL model_cycle_done t=%0t: got %0b want %0b", $time, cycle_done, m_done);
        end
    endtask

    task automatic set_cfg(int mn, int mx, int hh, int hl, int per);
        duty_min        = DUTY_W'(mn);
        duty_max        = DUTY_W'(mx);
        hold_high_steps = HOLD_W'(hh);
        hold_low_steps  = HOLD_W'(hl);
        step_period     = TICK_W'(per);
    endtask

    task automatic test_reset();
        bit found;
        rst = 1; enable = 1; pwm_sync = 1;
        set_cfg($urandom_range(0, 100), $urandom_range(101, 255), 1, 1, 1);
        cyc(); cyc();
        total++;
        if (duty_cycle !== 8'd0 || phase !== 3'd0 || cycle_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got duty=%0d phase=%0d done=%0b want 0/0/0", duty_cycle, phase, cycle_done);
        end
        rst = 0; enable = 0;
        cyc();
        set_cfg(30, 60, 2, 2, 1);
        enable = 1;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            cyc();
            if (duty_cycle == 8'd37 && phase == 3'd1) found = 1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL reach_ramp_37: got not reached want duty 37 in RAMP_UP"); end
        rst = 1;
        cyc();
        rst = 0;
        total++;
        if (duty_cycle !== 8'd0) begin bad++; $display("FAIL mid_ramp_reset_duty: got %0d want 0", duty_cycle); end
        total++;
        if (phase !== 3'd0) begin bad++; $display("FAIL mid_ramp_reset_phase: got %0d want 0", phase); end
        total++;
        if (cycle_done !== 1'b0) begin bad++; $display("FAIL mid_ramp_reset_done: got %0b want 0", cycle_done); end
        cyc();
        total++;
        if (duty_cycle !== 8'd30 || phase !== 3'd1) begin
            bad++;
            $display("FAIL restart_from_min: got duty=%0d phase=%0d want 30/1", duty_cycle, phase);
        end
    endtask

    task automatic test_full_envelope();
        int exp_seq[11] = '{10, 11, 12, 13, 13, 13, 13, 12, 11, 10, 10};
        int got[$];
        int n;
        enable = 0; cyc();
        set_cfg(10, 13, 2, 1, 1);
        pwm_sync = 1; enable = 1;
        cyc();
        got.push_back(int'(duty_cycle));
        n = 0;
        while (!cycle_done && n < 40) begin
            cyc();
            n++;
            if (!cycle_done) got.push_back(int'(duty_cycle));
        end
        total++;
        if (!cycle_done) begin bad++; $display("FAIL envelope_done_timeout: got no pulse want pulse"); end
        total++;
        if (got.size() != 11) begin bad++; $display("FAIL breath_length: got %0d want 11", got.size()); end
        for (int i = 0; i < 11 && i < got.size(); i++) begin
            total++;
            if (got[i] != exp_seq[i]) begin
                bad++;
                $display("FAIL envelope_step%0d: got %0d want %0d", i, got[i], exp_seq[i]);
            end
        end
        n = 0;
        do begin cyc(); n++; end while (!cycle_done && n < 40);
        total++;
        if (n != 11) begin bad++; $display("FAIL breath_period: got %0d want 11", n); end
    endtask

    task automatic test_sync_alignment();
        logic [DUTY_W-1:0] prev_duty;
        logic [2:0]        prev_phase;
        bit                s;
        int                nchange;
        int                diff;
        enable = 0; pwm_sync = 0; cyc();
        set_cfg(20, 40, 3, 3, 4);
        enable = 1;
        cyc();
        prev_duty = duty_cycle; prev_phase = phase; nchange = 0;
        for (int i = 0; i < 200; i++) begin
            pwm_sync = ((i % 10) == 9);
            s = pwm_sync;
            cyc();
            if (duty_cycle != prev_duty || phase != prev_phase) begin
                nchange++;
                total++;
                if (!s) begin bad++; $display("FAIL change_without_sync: got change at i=%0d want none", i); end
                diff = int'(duty_cycle) - int'(prev_duty);
                if (diff < 0) diff = -diff;
                total++;
                if (diff > 1) begin bad++; $display("FAIL multi_step: got delta %0d want <=1", diff); end
            end
            prev_duty = duty_cycle; prev_phase = phase;
        end
        total++;
        if (nchange == 0) begin bad++; $display("FAIL sync_progress: got 0 changes want >0"); end
        pwm_sync = 0;
    endtask

    task automatic test_degenerate();
        int exp_d;
        int last;
        for (int k = 0; k < 2; k++) begin
            enable = 0; cyc();
            if (k == 0) set_cfg(50, 50, 0, 0, 1);
            else        set_cfg(60, 40, 0, 0, 1);
            exp_d = (k == 0) ? 50 : 60;
            pwm_sync = 1; enable = 1;
            cyc();
            last = -1;
            for (int i = 0; i < 20; i++) begin
                cyc();
                total++;
                if (duty_cycle !== DUTY_W'(exp_d)) begin
                    bad++;
                    $display("FAIL degenerate_duty k=%0d: got %0d want %0d", k, duty_cycle, exp_d);
                end
                if (cycle_done) begin
                    if (last >= 0) begin
                        total++;
                        if (i - last != 2) begin bad++; $display("FAIL degenerate_period k=%0d: got %0d want 2", k, i - last); end
                    end
                    last = i;
                end
            end
            total++;
            if (last < 0) begin bad++; $display("FAIL degenerate_no_done k=%0d: got none want pulses", k); end
        end
    endtask

    task automatic test_config_latch();
        bit found;
        int peak;
        int n;
        enable = 0; cyc();
        set_cfg(50, 200, 1, 1, 1);
        pwm_sync = 1; enable = 1;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            cyc();
            if (duty_cycle == 8'd120 && phase == 3'd1) found = 1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL latch_reach_120: got not reached want reached"); end
        duty_max = 8'd100;
        for (int b = 0; b < 2; b++) begin
            peak = 0; n = 0;
            while (n < 400) begin
                cyc();
                n++;
                if (cycle_done) break;
                if (int'(duty_cycle) > peak) peak = int'(duty_cycle);
            end
            total++;
            if (peak != ((b == 0) ? 200 : 100)) begin
                bad++;
                $display("FAIL latch_peak b=%0d: got %0d want %0d", b, peak, (b == 0) ? 200 : 100);
            end
        end
    endtask

    task automatic test_disable();
        bit found;
        enable = 0; cyc();
        set_cfg(30, 35, 5, 2, 2);
        pwm_sync = 1; enable = 1;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            cyc();
            if (phase == 3'd2) found = 1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL reach_hold_high: got not reached want reached"); end
        enable = 0;
        cyc();
        total++;
        if (phase !== 3'd0) begin bad++; $display("FAIL disable_phase: got %0d want 0", phase); end
        total++;
        if (duty_cycle !== 8'd0) begin bad++; $display("FAIL disable_duty: got %0d want 0", duty_cycle); end
    endtask

    task automatic test_zero_period();
        int tr0[$];
        int tr1[$];
        int v;
        for (int k = 0; k < 2; k++) begin
            enable = 0; cyc();
            set_cfg(5, 9, 2, 1, k);
            pwm_sync = 1; enable = 1;
            for (int i = 0; i < 40; i++) begin
                cyc();
                v = int'(duty_cycle) + (int'(phase) << 8) + (int'(cycle_done) << 11);
                if (k == 0) tr0.push_back(v);
                else        tr1.push_back(v);
            end
        end
        for (int i = 0; i < 40; i++) begin
            total++;
            if (tr0[i] != tr1[i]) begin
                bad++;
                $display("FAIL zero_period_trace%0d: got %0h want %0h", i, tr0[i], tr1[i]);
            end
        end
    endtask

    task automatic test_random();
        int mn;
        for (int r = 0; r < 6; r++) begin
            enable = 0; rst = 0; cyc();
            mn = $urandom_range(0, 200);
            set_cfg(mn, ($urandom_range(0, 4) == 0) ? $urandom_range(0, 255) : mn + $urandom_range(0, 20),
                    $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 5));
            enable = 1;
            for (int i = 0; i < 300; i++) begin
                pwm_sync = ($urandom_range(0, 2) == 0);
                enable   = ($urandom_range(0, 99) != 0);
                rst      = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 49) == 0) duty_max = DUTY_W'($urandom_range(0, 255));
                if ($urandom_range(0, 49) == 0) step_period = TICK_W'($urandom_range(0, 5));
                cyc();
            end
            rst = 0;
        end
    endtask

    initial begin
        rst = 1; enable = 0; pwm_sync = 0;
        set_cfg(0, 0, 0, 0, 1);
        test_reset();
        test_full_envelope();
        test_sync_alignment();
        test_degenerate();
        test_config_latch();
        test_disable();
        test_zero_period();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
